// File: rtl/cart_bk_sync.sv
// Cartridge backup-RAM sync: streams battery RAM and an optional
// RTC sector between the cart and an SD image, one sector at a time.
module cart_bk_sync (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cart_download,
  input  logic        has_save,
  input  logic [7:0]  ram_mask_file,
  input  logic        rtc_present,
  input  logic        cram_wr,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        bk_save,
  output logic        bk_pending,
  output logic        busy,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  output logic        bk_wr,
  output logic        bk_rtc_wr,
  output logic [16:0] bk_addr,
  output logic [15:0] bk_data,
  input  logic [15:0] bk_q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_NEXT
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       dir;
  logic       dir_nx;
  logic [8:0] lba;
  logic [8:0] lba_nx;
  logic [8:0] last;
  logic [8:0] last_nx;
  logic       mounted;
  logic       bk_save_d;
  logic       done;

  logic [31:0] img_sect;
  logic [8:0]  span;
  logic [8:0]  load_last;
  logic        img_valid;
  logic        load_go;
  logic        save_go;
  logic        rtc_sect;
  logic        wr_ok;

  assign img_sect  = img_size[40:9];
  assign span      = {1'b0, ram_mask_file} + {8'd0, rtc_present};
  assign img_valid = img_size != 64'd0;

  // A start is refused while sd_ack is high so a host still holding
  // the buffer after an abort cannot be confused with a new transfer.
  assign load_go = img_mounted & has_save & img_valid
                 & ~cart_download & ~sd_ack;
  assign save_go = bk_save & ~bk_save_d & has_save & ~img_readonly
                 & mounted & ~cart_download & ~sd_ack;

  // Last sector of a load, shortened when the image is too small.
  always_comb begin
    load_last = span;
    if (img_sect == 32'd0)
      load_last = 9'd0;
    else if (img_sect <= {23'd0, span})
      load_last = img_sect[8:0] - 9'd1;
  end

  // Sequencer next-state: start, request, wait for ack drop, advance.
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    lba_nx   = lba;
    last_nx  = last;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load_go) begin
          state_nx = S_REQ;
          dir_nx   = 1'b0;
          lba_nx   = 9'd0;
          last_nx  = load_last;
        end else if (save_go) begin
          state_nx = S_REQ;
          dir_nx   = 1'b1;
          lba_nx   = 9'd0;
          last_nx  = span;
        end
      end
      S_REQ: begin
        if (sd_ack)
          state_nx = S_XFER;
      end
      S_XFER: begin
        if (!sd_ack)
          state_nx = S_NEXT;
      end
      S_NEXT: begin
        if (lba == last) begin
          state_nx = S_IDLE;
          done     = 1'b1;
        end else begin
          lba_nx   = lba + 9'd1;
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencer state, sector counter and transfer bounds.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= S_IDLE;
      dir   <= 1'b0;
      lba   <= 9'd0;
      last  <= 9'd0;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
      lba   <= lba_nx;
      last  <= last_nx;
    end
  end

  // Mount tracking, save-request edge history and dirty flag.
  always_ff @(posedge clk_sys) begin
    bk_save_d <= bk_save;
    if (reset) begin
      mounted    <= 1'b0;
      bk_pending <= 1'b0;
    end else begin
      if (img_mounted && img_valid)
        mounted <= 1'b1;
      if (cram_wr)
        bk_pending <= 1'b1;
      else if (done)
        bk_pending <= 1'b0;
    end
  end

  assign busy   = state != S_IDLE;
  assign sd_rd  = (state == S_REQ) & ~dir;
  assign sd_wr  = (state == S_REQ) & dir;
  assign sd_lba = {24'd0, lba[7:0]};

  assign rtc_sect = lba > {1'b0, ram_mask_file};
  assign bk_addr  = rtc_sect ? {9'd0, sd_buff_addr}
                             : {1'b0, lba[7:0], sd_buff_addr};
  assign bk_data  = sd_buff_dout;

  assign wr_ok     = sd_buff_wr & sd_ack & ~dir & busy;
  assign bk_wr     = wr_ok & ~rtc_sect;
  assign bk_rtc_wr = wr_ok & rtc_sect;

  assign sd_buff_din = bk_q;

endmodule
